// File: rtl/mc_fsm_controller.sv
// Multicycle MIPS control FSM: sequences a shared memory/ALU datapath, stalls on mem_ready,
// aborts a stalled access after TIMEOUT cycles. Define JAL_LINK_EN to add the jal state and link output.
module mc_fsm_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [3:0] alucontrol,
    output logic       illegal,
    output logic       mem_err,
`ifdef JAL_LINK_EN
    output logic       link,
`endif
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
        JR     = 4'd12, JAL    = 4'd13
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          expired;
    logic          link_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Last stalled cycle of an access; a ready in this same cycle still completes it.
    assign expired = (wait_q == CW'(TIMEOUT - 1)) && !mem_ready;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        alucontrol = 4'b0010;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        link_d     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready)    state_d = DECODE;
                else if (expired) mem_err = 1'b1;
            end
            DECODE: begin
                alusrcb = 2'b11;
                state_d = FETCH;
                case (op)
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000000: begin
                        case (funct)
                            6'b100000, 6'b100010, 6'b100100,
                            6'b100101, 6'b101010: state_d = EXEC;
                            6'b001000:            state_d = JR;
                            default:              illegal = 1'b1;
                        endcase
                    end
                    6'b000100, 6'b000101: state_d = BRANCH;
                    6'b001000:            state_d = ADDIEX;
                    6'b000010:            state_d = JUMP;
`ifdef JAL_LINK_EN
                    6'b000011:            state_d = JAL;
`endif
                    default:              illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = MEMWB;
                else if (expired) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) state_d = FETCH;
                else if (expired) begin
                    mem_err = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = 4'b0110;
                    6'b100100: alucontrol = 4'b0000;
                    6'b100101: alucontrol = 4'b0001;
                    6'b101010: alucontrol = 4'b0111;
                    default:   alucontrol = 4'b0010;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 4'b0110;
                pcsrc      = 2'b01;
                pcen       = zero ^ op[0];
                state_d    = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = FETCH;
            end
            JR: begin
                pcsrc   = 2'b11;
                pcen    = 1'b1;
                state_d = FETCH;
            end
`ifdef JAL_LINK_EN
            JAL: begin
                pcsrc    = 2'b10;
                pcen     = 1'b1;
                regwrite = 1'b1;
                link_d   = 1'b1;
                state_d  = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase

        // Counter restarts on every exit from a stalled access, so each new request starts at 0.
        wait_d = (mem_req && !mem_ready && !mem_err) ? wait_q + CW'(1) : '0;

        if (reset) begin
            mem_req    = 1'b0;
            iord       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            pcen       = 1'b0;
            alucontrol = 4'b0000;
            illegal    = 1'b0;
            mem_err    = 1'b0;
            link_d     = 1'b0;
        end
    end

`ifdef JAL_LINK_EN
    assign link = link_d;
`endif
    assign state = state_q;

endmodule

// File: tb/tb_mc_fsm_controller.sv
// Bench for mc_fsm_controller: directed vector table, hand-written stall/timeout/reset cases,
// then random instruction streams checked against an instruction-level path model.
module tb_mc_fsm_controller;
    localparam int TO = 16;
`ifdef JAL_LINK_EN
    localparam bit JAL = 1'b1;
`else
    localparam bit JAL = 1'b0;
`endif
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                           BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, JALOP = 6'b000011;
    localparam logic [3:0] A = 4'b0010;

    logic clk = 1'b0, reset = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic zero = 1'b0, mem_ready = 1'b0;
    logic mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol, state;
    logic illegal, mem_err, lnk;
    int vectors = 0, errs = 0;

    always #5 clk = ~clk;

    mc_fsm_controller #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
        .illegal(illegal), .mem_err(mem_err),
`ifdef JAL_LINK_EN
        .link(lnk),
`endif
        .state(state));
`ifndef JAL_LINK_EN
    assign lnk = 1'b0;
`endif

    typedef struct {
        logic rst; logic [5:0] op, funct; logic zero, rdy;
        logic [3:0] st; logic mreq, irw, pe, rw, ill, merr; logic [3:0] aluc;
    } vec_t;
    vec_t tbl[$];

    // Static control word per state: {mreq,iord,memwr,irwr,regdst,memtoreg,regwr,alusrca,srcb[2],pcsrc[2],pcen}
    logic [12:0] st_tab [14] = '{
        13'b1000000001000, 13'b0000000011000, 13'b0000000110000, 13'b1100000000000,
        13'b0000011000000, 13'b1110000000000, 13'b0000000100000, 13'b0000101000000,
        13'b0000000100010, 13'b0000000110000, 13'b0000001000000, 13'b0000000000101,
        13'b0000000000111, 13'b0000001000101};

    function automatic logic [23:0] act_sig();
        return {state, mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, pcen, alucontrol, illegal, mem_err, lnk};
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic [23:0] model_sig(input int s, input logic rdy, ill, merr);
        logic [12:0] c;
        logic [3:0]  al;
        c = st_tab[s];
        if (s == 0) begin c[9] = rdy; c[0] = rdy; end
        if (s == 8) c[0] = zero ^ op[0];
        al = (s == 6) ? alu_of(funct) : (s == 8) ? 4'b0110 : A;
        return {4'(s), c, al, ill, merr, (s == 13)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic step(); @(posedge clk); #1; endtask

    task automatic do_reset();
        reset = 1'b1; #1; step(); reset = 1'b0;
    endtask

    task automatic add(input logic r, input logic [5:0] o, f, input logic z, rd,
                       input logic [3:0] s, input logic mq, iw, pe, rw, il, me, input logic [3:0] al);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rd; v.st = s;
        v.mreq = mq; v.irw = iw; v.pe = pe; v.rw = rw; v.ill = il; v.merr = me; v.aluc = al;
        tbl.push_back(v);
    endtask

    task automatic fd(input logic [5:0] o, f, input logic z);
        add(0, o, f, z, 1, 0, 1, 1, 1, 0, 0, 0, A);
        add(0, o, f, z, 1, 1, 0, 0, 0, 0, 0, 0, A);
    endtask

    initial begin
        int path[$];
        #1;
        // ---- directed table ----
        repeat (3) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        add(0, LW, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, A);
        add(0, LW, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, A);
        add(0, LW, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, A);
        add(0, LW, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, A);
        add(0, LW, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, A);
        add(0, LW, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, A);
        add(0, LW, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0, A);
        fd(RT, 6'b100000, 0); add(0, RT, 6'b100000, 0, 1, 6, 0, 0, 0, 0, 0, 0, 4'b0010);
                              add(0, RT, 6'b100000, 0, 1, 7, 0, 0, 0, 1, 0, 0, A);
        fd(RT, 6'b100010, 0); add(0, RT, 6'b100010, 0, 1, 6, 0, 0, 0, 0, 0, 0, 4'b0110);
                              add(0, RT, 6'b100010, 0, 1, 7, 0, 0, 0, 1, 0, 0, A);
        fd(RT, 6'b101010, 0); add(0, RT, 6'b101010, 0, 1, 6, 0, 0, 0, 0, 0, 0, 4'b0111);
                              add(0, RT, 6'b101010, 0, 1, 7, 0, 0, 0, 1, 0, 0, A);
        fd(RT, 6'b100101, 0); add(0, RT, 6'b100101, 0, 1, 6, 0, 0, 0, 0, 0, 0, 4'b0001);
                              add(0, RT, 6'b100101, 0, 1, 7, 0, 0, 0, 1, 0, 0, A);
        fd(BNE, 0, 0); add(0, BNE, 0, 0, 1, 8, 0, 0, 1, 0, 0, 0, 4'b0110);
        fd(BEQ, 0, 0); add(0, BEQ, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 4'b0110);
        fd(BEQ, 0, 1); add(0, BEQ, 0, 1, 1, 8, 0, 0, 1, 0, 0, 0, 4'b0110);
        add(0, 6'b111111, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, A);
        add(0, 6'b111111, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, A);
        add(0, RT, 6'b111111, 0, 1, 0, 1, 1, 1, 0, 0, 0, A);
        add(0, RT, 6'b111111, 0, 1, 1, 0, 0, 0, 0, 1, 0, A);
        fd(RT, 6'b001000, 0); add(0, RT, 6'b001000, 0, 1, 12, 0, 0, 1, 0, 0, 0, A);
        fd(J, 0, 0);          add(0, J, 0, 0, 1, 11, 0, 0, 1, 0, 0, 0, A);
        fd(ADDI, 0, 0);       add(0, ADDI, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, A);
                              add(0, ADDI, 0, 0, 1, 10, 0, 0, 0, 1, 0, 0, A);
        fd(SW, 0, 0);         add(0, SW, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, A);
                              add(0, SW, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, A);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, A);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; op = tbl[i].op; funct = tbl[i].funct;
            zero = tbl[i].zero; mem_ready = tbl[i].rdy;
            #1;
            chk($sformatf("table[%0d]", i),
                32'({state, mem_req, irwrite, pcen, regwrite, illegal, mem_err, alucontrol}),
                32'({tbl[i].st, tbl[i].mreq, tbl[i].irw, tbl[i].pe, tbl[i].rw,
                     tbl[i].ill, tbl[i].merr, tbl[i].aluc}));
            step();
        end

        // ---- fetch timeout: mem_err on the 16th stalled cycle only ----
        do_reset(); op = 0; funct = 0; mem_ready = 0;
        for (int i = 1; i <= TO + 1; i++) begin
            #1;
            chk($sformatf("fetch_to_c%0d", i), {state, irwrite, pcen, mem_err},
                {4'd0, 1'b0, 1'b0, 1'(i == TO)});
            step();
        end

        // ---- ready on the timeout cycle wins ----
        do_reset();
        for (int i = 1; i < TO; i++) step();
        mem_ready = 1; #1;
        chk("ready_wins", {state, irwrite, mem_err}, {4'd0, 1'b1, 1'b0});
        step();
        chk("ready_wins_next", state, 4'd1);

        // ---- store stalled to timeout in MEMWR ----
        do_reset(); op = SW; mem_ready = 1;
        step(); step(); step(); mem_ready = 0;
        for (int i = 1; i <= TO; i++) begin
            #1;
            chk($sformatf("sw_to_c%0d", i), {state, memwrite, mem_err}, {4'd5, 1'b1, 1'(i == TO)});
            step();
        end
        chk("sw_to_exit", {state, memwrite, mem_req}, {4'd0, 1'b0, 1'b1});

        // ---- asynchronous reset mid-instruction ----
        do_reset(); op = LW; mem_ready = 1;
        step(); step(); step(); mem_ready = 0; #1;
        chk("pre_reset_memrd", state, 4'd3);
        reset = 1; #1;
        chk("async_reset", {state, mem_req, iord}, {4'd0, 1'b0, 1'b0});
        #1 reset = 0;
        step();
        chk("after_reset", state, 4'd0);

        // ---- jal ----
        do_reset(); op = JALOP; mem_ready = 1;
        step(); #1;
        chk("jal_decode", illegal, !JAL);
        step();
        chk("jal_next", {state, pcen, regwrite, lnk},
            JAL ? {4'd13, 1'b1, 1'b1, 1'b1} : {4'd0, 1'b1, 1'b0, 1'b0});

        // ---- random instruction stream vs path model ----
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int kind, idx, waited, stuck_from;
            bit stuck, ill_i;
            kind = $urandom_range(0, 14);
            funct = 6'($urandom);
            zero = 1'($urandom);
            ill_i = 0;
            case (kind)
                0: begin op = LW; path = '{0, 1, 2, 3, 4}; end
                1: begin op = SW; path = '{0, 1, 2, 5}; end
                2, 3, 4, 5, 6: begin
                    op = RT;
                    case (kind)
                        2: funct = 6'b100000; 3: funct = 6'b100010; 4: funct = 6'b100100;
                        5: funct = 6'b100101; default: funct = 6'b101010;
                    endcase
                    path = '{0, 1, 6, 7};
                end
                7: begin op = RT; funct = 6'b001000; path = '{0, 1, 12}; end
                8: begin op = BEQ; path = '{0, 1, 8}; end
                9: begin op = BNE; path = '{0, 1, 8}; end
                10: begin op = ADDI; path = '{0, 1, 9, 10}; end
                11: begin op = J; path = '{0, 1, 11}; end
                12: begin op = 6'b111111; path = '{0, 1}; ill_i = 1; end
                13: begin op = RT; funct = 6'b110011; path = '{0, 1}; ill_i = 1; end
                default: begin
                    op = JALOP;
                    if (JAL) path = '{0, 1, 13};
                    else begin path = '{0, 1}; ill_i = 1; end
                end
            endcase
            stuck = ($urandom_range(0, 9) == 0);
            stuck_from = $urandom_range(0, path.size() - 1);
            idx = 0; waited = 0;
            while (idx < path.size()) begin
                int s;
                bit mem, eerr;
                s = path[idx];
                mem = (s == 0) || (s == 3) || (s == 5);
                mem_ready = (stuck && idx >= stuck_from) ? 1'b0 : ($urandom_range(0, 3) != 0);
                #1;
                eerr = mem && !mem_ready && (waited == TO - 1);
                chk($sformatf("rand%0d_s%0d", n, s), 32'(act_sig()),
                    32'(model_sig(s, mem_ready, ill_i && s == 1, eerr)));
                step();
                if (eerr) break;
                if (mem && !mem_ready) waited++;
                else begin waited = 0; idx++; end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
